// File: rtl/mem_requester.sv
// Single-outstanding memory requester: accepts one host command, drives a
// one-hot word select toward a memory responder, waits with timeout, returns a response.
module mem_requester #(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_op_i,
  input  logic [ADDR_W-1:0]      cmd_addr_i,
  input  logic [7:0]             cmd_wdata_i,
  output logic [2**ADDR_W-1:0]   mem_select_o,
  output logic                   mem_op_o,
  output logic [7:0]             mem_wdata_o,
  input  logic [7:0]             mem_rdata_i,
  input  logic                   mem_valid_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [7:0]             rsp_data_o,
  output logic                   rsp_err_o
);

  localparam int NSEL  = 2**ADDR_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic               cmdOp_q, cmdOp_d;
  logic [ADDR_W-1:0]  cmdAddr_q, cmdAddr_d;
  logic [7:0]         cmdWdata_q, cmdWdata_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [7:0]         rspData_q, rspData_d;
  logic               rspErr_q, rspErr_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cmdOp_q    <= 1'b0;
      cmdAddr_q  <= '0;
      cmdWdata_q <= '0;
      waitCnt_q  <= '0;
      rspData_q  <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmdOp_q    <= cmdOp_d;
      cmdAddr_q  <= cmdAddr_d;
      cmdWdata_q <= cmdWdata_d;
      waitCnt_q  <= waitCnt_d;
      rspData_q  <= rspData_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // mem_valid is only looked at in WAIT; a completion on the last WAIT cycle beats the timeout
  always_comb begin
    state_d    = state_q;
    cmdOp_d    = cmdOp_q;
    cmdAddr_d  = cmdAddr_q;
    cmdWdata_d = cmdWdata_q;
    waitCnt_d  = waitCnt_q;
    rspData_d  = rspData_q;
    rspErr_d   = rspErr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          cmdOp_d    = cmd_op_i;
          cmdAddr_d  = cmd_addr_i;
          cmdWdata_d = cmd_wdata_i;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        waitCnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (waitCnt_q != CNT_LAST) waitCnt_d = waitCnt_q + CNT_ONE;
        if (mem_valid_i) begin
          rspData_d = cmdOp_q ? mem_rdata_i : 8'h00;
          rspErr_d  = 1'b0;
          state_d   = S_RESP;
        end else if (waitCnt_q == CNT_LAST) begin
          rspData_d = 8'h00;
          rspErr_d  = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = 1'b0;
    mem_select_o = '0;
    mem_op_o     = 1'b0;
    mem_wdata_o  = 8'h00;
    rsp_valid_o  = 1'b0;
    rsp_data_o   = 8'h00;
    rsp_err_o    = 1'b0;
    case (state_q)
      S_IDLE: cmd_ready_o = 1'b1;
      S_ISSUE, S_WAIT: begin
        mem_select_o[cmdAddr_q] = 1'b1;
        mem_op_o                = cmdOp_q;
        mem_wdata_o             = cmdWdata_q;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = rspData_q;
        rsp_err_o   = rspErr_q;
      end
      default: cmd_ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: expected responses queued at command time and
// compared when rsp_valid appears.
module tb_mem_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmdValid;
  logic       cmdReady;
  logic       cmdOp;
  logic [1:0] cmdAddr;
  logic [7:0] cmdWdata;
  logic [3:0] memSelect;
  logic       memOp;
  logic [7:0] memWdata;
  logic [7:0] memRdata;
  logic       memValid;
  logic       rspValid;
  logic       rspReady;
  logic [7:0] rspData;
  logic       rspErr;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  mem_requester #(.ADDR_W(2), .TIMEOUT(15)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cmd_valid_i  (cmdValid),
    .cmd_ready_o  (cmdReady),
    .cmd_op_i     (cmdOp),
    .cmd_addr_i   (cmdAddr),
    .cmd_wdata_i  (cmdWdata),
    .mem_select_o (memSelect),
    .mem_op_o     (memOp),
    .mem_wdata_o  (memWdata),
    .mem_rdata_i  (memRdata),
    .mem_valid_i  (memValid),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_data_o   (rspData),
    .rsp_err_o    (rspErr)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmdValid = 1'b0; cmdOp = 1'b0; cmdAddr = 2'd0; cmdWdata = 8'h00;
    memRdata = 8'h00; memValid = 1'b0; rspReady = 1'b1;
    tick();
    cmdValid = 1'b1; memValid = 1'b1;
    tick();
    nChecks++; if (cmdReady !== 1'b1) begin nFails++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmdReady); end
    nChecks++; if (memSelect !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_mem_select: got %b expected 0000", memSelect); end
    nChecks++; if (memOp !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_op: got %b expected 0", memOp); end
    nChecks++; if (memWdata !== 8'h00) begin nFails++; $display("[TB] FAIL reset_mem_wdata: got %h expected 00", memWdata); end
    nChecks++; if (rspValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rspValid); end
    nChecks++; if (rspData !== 8'h00) begin nFails++; $display("[TB] FAIL reset_rsp_data: got %h expected 00", rspData); end
    nChecks++; if (rspErr !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rspErr); end
    cmdValid = 1'b0; memValid = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    exp_t exp;
    cmdValid = 1'b1; cmdOp = 1'b0; cmdAddr = 2'd2; cmdWdata = 8'hA5; rspReady = 1'b1;
    sbQ.push_back('{data: 8'h00, err: 1'b0});
    tick();
    cmdValid = 1'b0; cmdWdata = 8'h00; cmdAddr = 2'd0;
    nChecks++; if (memSelect !== 4'b0100) begin nFails++; $display("[TB] FAIL write_issue_select: got %b expected 0100", memSelect); end
    nChecks++; if (memOp !== 1'b0) begin nFails++; $display("[TB] FAIL write_issue_op: got %b expected 0", memOp); end
    nChecks++; if (memWdata !== 8'hA5) begin nFails++; $display("[TB] FAIL write_issue_wdata: got %h expected a5", memWdata); end
    nChecks++; if (cmdReady !== 1'b0) begin nFails++; $display("[TB] FAIL write_issue_ready: got %b expected 0", cmdReady); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++; if (memSelect !== 4'b0100 || memWdata !== 8'hA5 || memOp !== 1'b0 || rspValid !== 1'b0)
        begin nFails++; $display("[TB] FAIL write_wait_hold[%0d]: got sel=%b wd=%h op=%b rv=%b expected sel=0100 wd=a5 op=0 rv=0", i, memSelect, memWdata, memOp, rspValid); end
      if (i == 2) begin memValid = 1'b1; memRdata = 8'hFF; end
    end
    tick();
    memValid = 1'b0;
    nChecks++;
    if (rspValid !== 1'b1 || sbQ.size() == 0) begin
      nFails++; $display("[TB] FAIL write_rsp_valid: got %b expected 1", rspValid);
    end else begin
      exp = sbQ.pop_front();
      nChecks++; if (rspData !== exp.data) begin nFails++; $display("[TB] FAIL write_rsp_data: got %h expected %h", rspData, exp.data); end
      nChecks++; if (rspErr !== exp.err) begin nFails++; $display("[TB] FAIL write_rsp_err: got %b expected %b", rspErr, exp.err); end
    end
    nChecks++; if (memSelect !== 4'b0000 || memWdata !== 8'h00) begin nFails++; $display("[TB] FAIL write_resp_select: got sel=%b wd=%h expected sel=0000 wd=00", memSelect, memWdata); end
    tick();
    nChecks++; if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin nFails++; $display("[TB] FAIL write_back_idle: got ready=%b rv=%b expected ready=1 rv=0", cmdReady, rspValid); end
  endtask

  task automatic test_back_to_back();
    exp_t exp;
    logic [7:0] rdVals[2];
    logic [1:0] addrs[2];
    logic [3:0] sels[2];
    rdVals[0] = 8'h3C; rdVals[1] = 8'hC5;
    addrs[0]  = 2'd1;  addrs[1]  = 2'd3;
    sels[0]   = 4'b0010; sels[1] = 4'b1000;
    rspReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nChecks++; if (cmdReady !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_accept[%0d]: got ready=%b expected 1", k, cmdReady); end
      cmdValid = 1'b1; cmdOp = 1'b1; cmdAddr = addrs[k]; cmdWdata = 8'h00;
      sbQ.push_back('{data: rdVals[k], err: 1'b0});
      tick();
      cmdValid = 1'b0;
      nChecks++; if (memSelect !== sels[k] || memOp !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_issue[%0d]: got sel=%b op=%b expected sel=%b op=1", k, memSelect, memOp, sels[k]); end
      tick();
      memValid = 1'b1; memRdata = rdVals[k];
      tick();
      memValid = 1'b0; memRdata = 8'h00;
      nChecks++;
      if (rspValid !== 1'b1 || sbQ.size() == 0) begin
        nFails++; $display("[TB] FAIL b2b_rsp_valid[%0d]: got %b expected 1", k, rspValid);
      end else begin
        exp = sbQ.pop_front();
        nChecks++; if (rspData !== exp.data) begin nFails++; $display("[TB] FAIL b2b_rsp_data[%0d]: got %h expected %h", k, rspData, exp.data); end
        nChecks++; if (rspErr !== exp.err) begin nFails++; $display("[TB] FAIL b2b_rsp_err[%0d]: got %b expected %b", k, rspErr, exp.err); end
      end
      tick();
    end
    nChecks++; if (cmdReady !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_final_idle: got ready=%b expected 1", cmdReady); end
  endtask

  task automatic test_timeout();
    exp_t exp;
    int waits;
    bit seen;
    cmdValid = 1'b1; cmdOp = 1'b1; cmdAddr = 2'd0; rspReady = 1'b0;
    memRdata = 8'h77; memValid = 1'b0;
    sbQ.push_back('{data: 8'h00, err: 1'b1});
    tick();
    cmdValid = 1'b0;
    waits = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (rspValid === 1'b1) seen = 1'b1;
      else waits++;
    end
    nChecks++;
    if (!seen) begin
      nFails++; $display("[TB] FAIL timeout_no_rsp: got no rsp_valid within 40 cycles expected rsp after 15 WAIT cycles");
    end else begin
      nChecks++; if (waits != 15) begin nFails++; $display("[TB] FAIL timeout_wait_count: got %0d expected 15", waits); end
      exp = sbQ.pop_front();
      nChecks++; if (rspData !== exp.data) begin nFails++; $display("[TB] FAIL timeout_rsp_data: got %h expected %h", rspData, exp.data); end
      nChecks++; if (rspErr !== exp.err) begin nFails++; $display("[TB] FAIL timeout_rsp_err: got %b expected %b", rspErr, exp.err); end
    end
    rspReady = 1'b1;
    tick();
    nChecks++; if (cmdReady !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_back_idle: got %b expected 1", cmdReady); end
  endtask

  task automatic test_timeout_last_cycle();
    exp_t exp;
    cmdValid = 1'b1; cmdOp = 1'b1; cmdAddr = 2'd0; rspReady = 1'b1;
    sbQ.push_back('{data: 8'h96, err: 1'b0});
    tick();
    cmdValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 14) begin
        nChecks++; if (rspValid !== 1'b0 || memSelect !== 4'b0001) begin nFails++; $display("[TB] FAIL lastcyc_still_wait: got rv=%b sel=%b expected rv=0 sel=0001", rspValid, memSelect); end
        memValid = 1'b1; memRdata = 8'h96;
      end
    end
    tick();
    memValid = 1'b0; memRdata = 8'h00;
    nChecks++;
    if (rspValid !== 1'b1 || sbQ.size() == 0) begin
      nFails++; $display("[TB] FAIL lastcyc_rsp_valid: got %b expected 1", rspValid);
    end else begin
      exp = sbQ.pop_front();
      nChecks++; if (rspData !== exp.data) begin nFails++; $display("[TB] FAIL lastcyc_rsp_data: got %h expected %h", rspData, exp.data); end
      nChecks++; if (rspErr !== exp.err) begin nFails++; $display("[TB] FAIL lastcyc_rsp_err: got %b expected %b", rspErr, exp.err); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t exp;
    cmdValid = 1'b1; cmdOp = 1'b1; cmdAddr = 2'd2; rspReady = 1'b0;
    sbQ.push_back('{data: 8'hC3, err: 1'b0});
    tick();
    cmdValid = 1'b0;
    tick();
    memValid = 1'b1; memRdata = 8'hC3;
    tick();
    memValid = 1'b0; memRdata = 8'h00;
    if (sbQ.size() != 0) exp = sbQ.pop_front();
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (rspValid !== 1'b1 || rspData !== exp.data || rspErr !== exp.err || cmdReady !== 1'b0 || memSelect !== 4'b0000)
        begin nFails++; $display("[TB] FAIL backpressure_hold[%0d]: got rv=%b data=%h err=%b ready=%b sel=%b expected rv=1 data=%h err=%b ready=0 sel=0000",
                                 i, rspValid, rspData, rspErr, cmdReady, memSelect, exp.data, exp.err); end
      cmdValid = (i % 2 == 0); cmdOp = 1'b0; cmdAddr = 2'(i); cmdWdata = 8'h5A;
      tick();
    end
    cmdValid = 1'b0;
    rspReady = 1'b1;
    tick();
    nChecks++; if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin nFails++; $display("[TB] FAIL backpressure_release: got ready=%b rv=%b expected ready=1 rv=0", cmdReady, rspValid); end
    tick();
    nChecks++; if (cmdReady !== 1'b1 || memSelect !== 4'b0000) begin nFails++; $display("[TB] FAIL backpressure_no_ghost: got ready=%b sel=%b expected ready=1 sel=0000", cmdReady, memSelect); end
  endtask

  task automatic test_reset_in_wait();
    int stray;
    cmdValid = 1'b1; cmdOp = 1'b1; cmdAddr = 2'd3; rspReady = 1'b1;
    tick();
    cmdValid = 1'b0;
    tick();
    tick();
    nChecks++; if (memSelect !== 4'b1000) begin nFails++; $display("[TB] FAIL rstwait_select_before: got %b expected 1000", memSelect); end
    reset = 1'b1; memValid = 1'b1; memRdata = 8'hEE;
    tick();
    reset = 1'b0; memValid = 1'b0;
    nChecks++; if (memSelect !== 4'b0000) begin nFails++; $display("[TB] FAIL rstwait_select_after: got %b expected 0000", memSelect); end
    nChecks++; if (cmdReady !== 1'b1) begin nFails++; $display("[TB] FAIL rstwait_ready_after: got %b expected 1", cmdReady); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (rspValid !== 1'b0) stray++;
      tick();
    end
    nChecks++; if (stray != 0) begin nFails++; $display("[TB] FAIL rstwait_no_rsp: got %0d rsp_valid cycles expected 0", stray); end
  endtask

  task automatic test_spurious_valid();
    exp_t exp;
    memValid = 1'b1; memRdata = 8'h42; rspReady = 1'b1;
    tick();
    nChecks++; if (cmdReady !== 1'b1 || rspValid !== 1'b0 || memSelect !== 4'b0000) begin nFails++; $display("[TB] FAIL spurious_idle: got ready=%b rv=%b sel=%b expected ready=1 rv=0 sel=0000", cmdReady, rspValid, memSelect); end
    cmdValid = 1'b1; cmdOp = 1'b0; cmdAddr = 2'd0; cmdWdata = 8'h11;
    tick();
    cmdValid = 1'b0;
    nChecks++; if (memSelect !== 4'b0001 || memWdata !== 8'h11 || rspValid !== 1'b0) begin nFails++; $display("[TB] FAIL spurious_issue: got sel=%b wd=%h rv=%b expected sel=0001 wd=11 rv=0", memSelect, memWdata, rspValid); end
    tick();
    memValid = 1'b0;
    nChecks++; if (rspValid !== 1'b0 || memSelect !== 4'b0001) begin nFails++; $display("[TB] FAIL spurious_wait0: got rv=%b sel=%b expected rv=0 sel=0001", rspValid, memSelect); end
    tick();
    nChecks++; if (rspValid !== 1'b0) begin nFails++; $display("[TB] FAIL spurious_wait1: got rv=%b expected 0", rspValid); end
    memValid = 1'b1;
    sbQ.push_back('{data: 8'h00, err: 1'b0});
    tick();
    memValid = 1'b0;
    nChecks++;
    if (rspValid !== 1'b1 || sbQ.size() == 0) begin
      nFails++; $display("[TB] FAIL spurious_rsp_valid: got %b expected 1", rspValid);
    end else begin
      exp = sbQ.pop_front();
      nChecks++; if (rspData !== exp.data || rspErr !== exp.err) begin nFails++; $display("[TB] FAIL spurious_rsp: got data=%h err=%b expected data=%h err=%b", rspData, rspErr, exp.data, exp.err); end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_timeout();
    test_timeout_last_cycle();
    test_backpressure();
    test_reset_in_wait();
    test_spurious_valid();
    nChecks++; if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
